// File: rtl/matrix_assembler_pkg.sv
// Shared sizing, state encoding and flat-bus packing helpers for the matrix splitter/assembler pair.
// Pure declarations: no latency, no flow control.
package matrix_assembler_pkg;

  localparam int MATRIX_SIZE_DEF = 128;
  localparam int BLOCK_SIZE_DEF  = 64;
  localparam int DATA_WIDTH_DEF  = 16;
  localparam int BLOCKS_PER_SIDE = MATRIX_SIZE_DEF / BLOCK_SIZE_DEF;
  localparam int NUM_BLOCKS      = BLOCKS_PER_SIDE * BLOCKS_PER_SIDE;

  localparam logic [1:0] ST_IDLE_ENC = 2'd0;
  localparam logic [1:0] ST_FILL_ENC = 2'd1;
  localparam logic [1:0] ST_DONE_ENC = 2'd2;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE_ENC,
    FILL = ST_FILL_ENC,
    DONE = ST_DONE_ENC
  } asm_state_e;

  typedef struct packed {
    logic [1:0] row;
    logic [1:0] col;
  } blk_idx_t;

  // Bit offset of element [r][c] in a row-major flattened matrix.
  function automatic int elem_lsb(input int r, input int c, input int ms, input int dw);
    return (r * ms + c) * dw;
  endfunction

  function automatic int blk_bit(input int r, input int c, input int bps);
    return r * bps + c;
  endfunction

endpackage

// File: rtl/matrix_assembler_ctrl.sv
// Block-arrival FSM: row counter, latched block indices, arrival mask, error/duplicate pulses.
// Row-write enable is combinational on the accepting beat; pulses are one cycle after it.
// Backpressure: ready_in drops while a completed matrix waits for ack_in.
module matrix_assembler_ctrl
  import matrix_assembler_pkg::*;
#(
  parameter int MATRIX_SIZE = MATRIX_SIZE_DEF,
  parameter int BLOCK_SIZE  = BLOCK_SIZE_DEF,
  localparam int BPS = MATRIX_SIZE / BLOCK_SIZE,
  localparam int NB  = BPS * BPS,
  localparam int AW  = $clog2(MATRIX_SIZE),
  localparam int RCW = $clog2(BLOCK_SIZE)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          valid_in,
  input  blk_idx_t      in_idx,
  input  logic          ack_in,
  output logic          ready_in,
  output logic          valid_out,
  output logic [NB-1:0] blocks_done,
  output logic          idx_err,
  output logic          dup_warn,
  output logic          wr_en,
  output logic [AW-1:0] wr_row,
  output logic [AW-1:0] wr_col
);

  asm_state_e     state;
  logic [RCW-1:0] row_cnt;
  blk_idx_t       lat_idx;
  blk_idx_t       cur_idx;
  logic [NB-1:0]  mask;
  logic [NB-1:0]  cur_bit;
  logic           accept;
  logic           idx_ok;

  always_comb begin
    accept  = valid_in && (state != DONE);
    idx_ok  = (int'(in_idx.row) < BPS) && (int'(in_idx.col) < BPS);
    cur_idx = (state == FILL) ? lat_idx : in_idx;
    cur_bit = NB'(1) << blk_bit(int'(cur_idx.row), int'(cur_idx.col), BPS);
    wr_en   = accept && ((state == FILL) || idx_ok);
    wr_row  = AW'(cur_idx.row) * AW'(BLOCK_SIZE) + AW'(row_cnt);
    wr_col  = AW'(cur_idx.col) * AW'(BLOCK_SIZE);
  end

  assign ready_in    = (state != DONE);
  assign valid_out   = (state == DONE);
  assign blocks_done = mask;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      row_cnt  <= '0;
      lat_idx  <= '0;
      mask     <= '0;
      idx_err  <= 1'b0;
      dup_warn <= 1'b0;
    end else begin
      idx_err  <= 1'b0;
      dup_warn <= 1'b0;
      case (state)
        IDLE: begin
          if (valid_in) begin
            if (!idx_ok) begin
              idx_err <= 1'b1;
            end else begin
              lat_idx  <= in_idx;
              dup_warn <= |(mask & cur_bit);
              row_cnt  <= RCW'(1);
              state    <= FILL;
            end
          end
        end
        FILL: begin
          if (valid_in) begin
            if (row_cnt == RCW'(BLOCK_SIZE - 1)) begin
              mask    <= mask | cur_bit;
              row_cnt <= '0;
              state   <= (&(mask | cur_bit)) ? DONE : IDLE;
            end else begin
              row_cnt <= row_cnt + RCW'(1);
            end
          end
        end
        DONE: begin
          // Storage is intentionally kept; only the arrival mask restarts.
          if (ack_in) begin
            mask  <= '0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/matrix_assembler.sv
// Rebuilds a full matrix from block-row beats and presents it as one flat bus until acknowledged.
// A row is visible on large_matrix_flat the cycle after its accepting edge.
// Backpressure: ready_in is low while valid_out is held; cleared by ack_in.
module matrix_assembler
  import matrix_assembler_pkg::*;
#(
  parameter int MATRIX_SIZE = MATRIX_SIZE_DEF,
  parameter int BLOCK_SIZE  = BLOCK_SIZE_DEF,
  parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
  localparam int BPS = MATRIX_SIZE / BLOCK_SIZE,
  localparam int NB  = BPS * BPS,
  localparam int AW  = $clog2(MATRIX_SIZE)
) (
  input  logic                                      clk,
  input  logic                                      rst_n,
  input  logic                                      valid_in,
  output logic                                      ready_in,
  input  logic [DATA_WIDTH*BLOCK_SIZE-1:0]          block_row_flat,
  input  logic [1:0]                                row_block_idx,
  input  logic [1:0]                                col_block_idx,
  output logic                                      valid_out,
  input  logic                                      ack_in,
  output logic [DATA_WIDTH*MATRIX_SIZE*MATRIX_SIZE-1:0] large_matrix_flat,
  output logic [NB-1:0]                             blocks_done,
  output logic                                      idx_err,
  output logic                                      dup_warn
);

  logic [DATA_WIDTH-1:0] mem [MATRIX_SIZE][MATRIX_SIZE];
  blk_idx_t              in_idx;
  logic                  wr_en;
  logic [AW-1:0]         wr_row;
  logic [AW-1:0]         wr_col;

  assign in_idx = '{row: row_block_idx, col: col_block_idx};

  matrix_assembler_ctrl #(
    .MATRIX_SIZE(MATRIX_SIZE),
    .BLOCK_SIZE (BLOCK_SIZE)
  ) u_ctrl (
    .clk        (clk),
    .rst_n      (rst_n),
    .valid_in   (valid_in),
    .in_idx     (in_idx),
    .ack_in     (ack_in),
    .ready_in   (ready_in),
    .valid_out  (valid_out),
    .blocks_done(blocks_done),
    .idx_err    (idx_err),
    .dup_warn   (dup_warn),
    .wr_en      (wr_en),
    .wr_row     (wr_row),
    .wr_col     (wr_col)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < MATRIX_SIZE; r++) begin
        for (int c = 0; c < MATRIX_SIZE; c++) begin
          mem[r][c] <= '0;
        end
      end
    end else if (wr_en) begin
      for (int j = 0; j < BLOCK_SIZE; j++) begin
        mem[wr_row][wr_col + AW'(j)] <= block_row_flat[j*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  for (genvar r = 0; r < MATRIX_SIZE; r++) begin : g_row
    for (genvar c = 0; c < MATRIX_SIZE; c++) begin : g_col
      assign large_matrix_flat[elem_lsb(r, c, MATRIX_SIZE, DATA_WIDTH) +: DATA_WIDTH] = mem[r][c];
    end
  end

endmodule

// File: tb/tb_matrix_assembler.sv
// Directed bench for matrix_assembler: block streaming, completion, backpressure, index errors, reset.
module tb_matrix_assembler;

  localparam int MS = 128;
  localparam int BS = 64;
  localparam int DW = 16;

  logic               clk;
  logic               rst_n;
  logic               valid_in;
  logic               ready_in;
  logic [DW*BS-1:0]   block_row_flat;
  logic [1:0]         row_block_idx;
  logic [1:0]         col_block_idx;
  logic               valid_out;
  logic               ack_in;
  logic [DW*MS*MS-1:0] large_matrix_flat;
  logic [3:0]         blocks_done;
  logic               idx_err;
  logic               dup_warn;

  int total = 0;
  int bad   = 0;

  logic [DW-1:0] exp_mem [MS][MS];

  matrix_assembler dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .valid_in         (valid_in),
    .ready_in         (ready_in),
    .block_row_flat   (block_row_flat),
    .row_block_idx    (row_block_idx),
    .col_block_idx    (col_block_idx),
    .valid_out        (valid_out),
    .ack_in           (ack_in),
    .large_matrix_flat(large_matrix_flat),
    .blocks_done      (blocks_done),
    .idx_err          (idx_err),
    .dup_warn         (dup_warn)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // kind 0: r*256+c, 1: all ones, 2: pattern xor 0x5A5A, 3: 0x7777
  function automatic logic [DW-1:0] gen(input int kind, input int r, input int c);
    case (kind)
      0:       return 16'(r * 256 + c);
      1:       return 16'hFFFF;
      2:       return 16'(r * 256 + c) ^ 16'h5A5A;
      default: return 16'h7777;
    endcase
  endfunction

  function automatic logic [DW-1:0] elem(input int r, input int c);
    return large_matrix_flat[(r * MS + c) * DW +: DW];
  endfunction

  function automatic int mem_diffs();
    int n = 0;
    for (int r = 0; r < MS; r++)
      for (int c = 0; c < MS; c++)
        if (elem(r, c) !== exp_mem[r][c]) n++;
    return n;
  endfunction

  task automatic clear_model();
    for (int r = 0; r < MS; r++)
      for (int c = 0; c < MS; c++)
        exp_mem[r][c] = '0;
  endtask

  task automatic drive_beat(input logic v, input logic [1:0] rb, input logic [1:0] cb,
                            input int kind, input int arow, input int cbase);
    logic [DW*BS-1:0] row;
    for (int j = 0; j < BS; j++) row[j*DW +: DW] = gen(kind, arow, cbase + j);
    valid_in       = v;
    row_block_idx  = rb;
    col_block_idx  = cb;
    block_row_flat = row;
    @(posedge clk);
    #1;
  endtask

  // Sends rows first..first+n-1 of block [rb,cb]; scramble drives wrong indices after row 0.
  task automatic send_rows(input int rb, input int cb, input int kind, input int first,
                           input int n, input bit scramble);
    for (int i = first; i < first + n; i++) begin
      logic [1:0] rbv;
      logic [1:0] cbv;
      rbv = 2'(rb);
      cbv = 2'(cb);
      if (scramble && i > 0) begin
        rbv = ~rbv;
        cbv = ~cbv;
      end
      drive_beat(1'b1, rbv, cbv, kind, rb * BS + i, cb * BS);
      for (int j = 0; j < BS; j++) exp_mem[rb * BS + i][cb * BS + j] = gen(kind, rb * BS + i, cb * BS + j);
    end
    valid_in = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    clear_model();
    total++; if (ready_in !== 1'b1) begin bad++; $display("FAIL reset_ready got=%0b exp=1", ready_in); end
    total++; if (valid_out !== 1'b0) begin bad++; $display("FAIL reset_valid_out got=%0b exp=0", valid_out); end
    total++; if (blocks_done !== 4'b0000) begin bad++; $display("FAIL reset_blocks_done got=%b exp=0000", blocks_done); end
    total++; if (idx_err !== 1'b0 || dup_warn !== 1'b0) begin bad++; $display("FAIL reset_pulses got=%0b%0b exp=00", idx_err, dup_warn); end
    total++; if (large_matrix_flat !== '0) begin bad++; $display("FAIL reset_storage got=nonzero exp=0"); end
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_single_block();
    send_rows(0, 0, 0, 0, 1, 0);
    total++; if (elem(0, 5) !== 16'd5) begin bad++; $display("FAIL single_first_row got=%0d exp=5", elem(0, 5)); end
    repeat (3) @(posedge clk);
    #1;
    send_rows(0, 0, 0, 1, 63, 0);
    total++; if (blocks_done !== 4'b0001) begin bad++; $display("FAIL single_mask got=%b exp=0001", blocks_done); end
    total++; if (valid_out !== 1'b0 || ready_in !== 1'b1) begin bad++; $display("FAIL single_flags got vo=%0b rdy=%0b exp vo=0 rdy=1", valid_out, ready_in); end
    total++; if (mem_diffs() !== 0) begin bad++; $display("FAIL single_storage got diffs=%0d exp=0", mem_diffs()); end
  endtask

  task automatic test_full_assembly();
    send_rows(0, 1, 0, 0, 64, 0);
    send_rows(1, 0, 0, 0, 64, 0);
    send_rows(1, 1, 0, 0, 63, 0);
    total++; if (valid_out !== 1'b0) begin bad++; $display("FAIL full_early_valid got=%0b exp=0", valid_out); end
    send_rows(1, 1, 0, 63, 1, 0);
    total++; if (valid_out !== 1'b1 || ready_in !== 1'b0) begin bad++; $display("FAIL full_done got vo=%0b rdy=%0b exp vo=1 rdy=0", valid_out, ready_in); end
    total++; if (blocks_done !== 4'b1111) begin bad++; $display("FAIL full_mask got=%b exp=1111", blocks_done); end
    total++; if (elem(0, 0) !== 16'd0 || elem(0, 127) !== 16'd127) begin bad++; $display("FAIL full_top_corners got=%0d,%0d exp=0,127", elem(0, 0), elem(0, 127)); end
    total++; if (elem(127, 0) !== 16'd32512 || elem(127, 127) !== 16'd32639) begin bad++; $display("FAIL full_bot_corners got=%0d,%0d exp=32512,32639", elem(127, 0), elem(127, 127)); end
    total++; if (mem_diffs() !== 0) begin bad++; $display("FAIL full_storage got diffs=%0d exp=0", mem_diffs()); end
  endtask

  task automatic test_backpressure_ack();
    for (int i = 0; i < 3; i++) drive_beat(1'b1, 2'd0, 2'd0, 1, i, 0);
    valid_in = 1'b0;
    total++; if (ready_in !== 1'b0 || valid_out !== 1'b1) begin bad++; $display("FAIL bp_flags got rdy=%0b vo=%0b exp rdy=0 vo=1", ready_in, valid_out); end
    total++; if (mem_diffs() !== 0) begin bad++; $display("FAIL bp_storage got diffs=%0d exp=0", mem_diffs()); end
    ack_in = 1'b1;
    @(posedge clk);
    #1;
    ack_in = 1'b0;
    total++; if (valid_out !== 1'b0 || ready_in !== 1'b1) begin bad++; $display("FAIL ack_flags got vo=%0b rdy=%0b exp vo=0 rdy=1", valid_out, ready_in); end
    total++; if (blocks_done !== 4'b0000) begin bad++; $display("FAIL ack_mask got=%b exp=0000", blocks_done); end
    total++; if (mem_diffs() !== 0) begin bad++; $display("FAIL ack_storage_kept got diffs=%0d exp=0", mem_diffs()); end
  endtask

  task automatic test_index();
    drive_beat(1'b1, 2'd2, 2'd0, 3, 0, 0);
    valid_in = 1'b0;
    total++; if (idx_err !== 1'b1) begin bad++; $display("FAIL idx_err_row got=%0b exp=1", idx_err); end
    total++; if (blocks_done !== 4'b0000 || mem_diffs() !== 0) begin bad++; $display("FAIL idx_no_write got mask=%b diffs=%0d exp mask=0000 diffs=0", blocks_done, mem_diffs()); end
    @(posedge clk);
    #1;
    total++; if (idx_err !== 1'b0) begin bad++; $display("FAIL idx_err_width got=%0b exp=0", idx_err); end
    drive_beat(1'b1, 2'd0, 2'd3, 3, 0, 0);
    valid_in = 1'b0;
    total++; if (idx_err !== 1'b1) begin bad++; $display("FAIL idx_err_col got=%0b exp=1", idx_err); end
    ack_in = 1'b1;
    @(posedge clk);
    #1;
    ack_in = 1'b0;
    total++; if (ready_in !== 1'b1 || valid_out !== 1'b0) begin bad++; $display("FAIL idle_ack_ignored got rdy=%0b vo=%0b exp rdy=1 vo=0", ready_in, valid_out); end
    send_rows(0, 1, 2, 0, 64, 1);
    total++; if (blocks_done !== 4'b0010) begin bad++; $display("FAIL idx_latched_mask got=%b exp=0010", blocks_done); end
    total++; if (mem_diffs() !== 0) begin bad++; $display("FAIL idx_latched_storage got diffs=%0d exp=0", mem_diffs()); end
  endtask

  task automatic test_duplicate();
    send_rows(1, 0, 0, 0, 1, 0);
    total++; if (dup_warn !== 1'b0) begin bad++; $display("FAIL dup_first_time got=%0b exp=0", dup_warn); end
    send_rows(1, 0, 0, 1, 63, 0);
    send_rows(1, 0, 1, 0, 1, 0);
    total++; if (dup_warn !== 1'b1) begin bad++; $display("FAIL dup_pulse got=%0b exp=1", dup_warn); end
    send_rows(1, 0, 1, 1, 1, 0);
    total++; if (dup_warn !== 1'b0) begin bad++; $display("FAIL dup_pulse_width got=%0b exp=0", dup_warn); end
    send_rows(1, 0, 1, 2, 62, 0);
    total++; if (blocks_done !== 4'b0110 || valid_out !== 1'b0) begin bad++; $display("FAIL dup_mask got=%b vo=%0b exp=0110 vo=0", blocks_done, valid_out); end
    total++; if (elem(64, 0) !== 16'hFFFF || elem(127, 63) !== 16'hFFFF) begin bad++; $display("FAIL dup_region got=%h,%h exp=ffff,ffff", elem(64, 0), elem(127, 63)); end
    send_rows(0, 0, 0, 0, 64, 0);
    total++; if (valid_out !== 1'b0 || blocks_done !== 4'b0111) begin bad++; $display("FAIL dup_three got vo=%0b mask=%b exp vo=0 mask=0111", valid_out, blocks_done); end
    send_rows(1, 1, 0, 0, 64, 0);
    total++; if (valid_out !== 1'b1) begin bad++; $display("FAIL dup_complete got=%0b exp=1", valid_out); end
    total++; if (mem_diffs() !== 0) begin bad++; $display("FAIL dup_storage got diffs=%0d exp=0", mem_diffs()); end
    ack_in = 1'b1;
    @(posedge clk);
    #1;
    ack_in = 1'b0;
  endtask

  task automatic test_reset_mid();
    send_rows(1, 1, 3, 0, 30, 0);
    total++; if (elem(64, 64) !== 16'h7777) begin bad++; $display("FAIL mid_partial got=%h exp=7777", elem(64, 64)); end
    #2 rst_n = 1'b0;
    #1;
    clear_model();
    total++; if (ready_in !== 1'b1 || valid_out !== 1'b0 || blocks_done !== 4'b0000) begin bad++; $display("FAIL mid_reset_flags got rdy=%0b vo=%0b mask=%b exp 1 0 0000", ready_in, valid_out, blocks_done); end
    total++; if (large_matrix_flat !== '0) begin bad++; $display("FAIL mid_reset_storage got=nonzero exp=0"); end
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
    send_rows(1, 1, 0, 0, 64, 0);
    total++; if (blocks_done !== 4'b1000) begin bad++; $display("FAIL mid_fresh_mask got=%b exp=1000", blocks_done); end
    total++; if (elem(64, 64) !== 16'd16448 || mem_diffs() !== 0) begin bad++; $display("FAIL mid_fresh_storage got=%0d diffs=%0d exp=16448 diffs=0", elem(64, 64), mem_diffs()); end
  endtask

  initial begin
    rst_n          = 1'b0;
    valid_in       = 1'b0;
    ack_in         = 1'b0;
    block_row_flat = '0;
    row_block_idx  = 2'd0;
    col_block_idx  = 2'd0;
    test_reset();
    test_single_block();
    test_full_assembly();
    test_backpressure_ack();
    test_index();
    test_duplicate();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
